// File: rtl/piso_serializer_32_bit_if.sv
// Bundle of data, handshake and frame signals between the upstream PIPO stage,
// the serializer and the downstream serial consumer.
//   Parallel_Data_In : word to serialize (from upstream PIPO output)
//   Load_In          : load request; accepted when Ready_Out=1
//   Ready_Out        : serializer can accept a word on this falling edge
//   Shift_Enable_In  : downstream consumes the current bit on this edge
//   Serial_Data_Out  : current serial bit
//   Serial_Valid_Out : Serial_Data_Out holds a valid frame bit
//   Frame_Start_Out  : first bit of a frame is being presented
//   Frame_Done_Out   : one-cycle pulse after the last bit is consumed
//   Bit_Count_Out    : index of the bit currently presented
// Modports: slave = serializer side, master = driver/consumer side.
interface piso_serializer_32_bit_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] Parallel_Data_In;
  logic                  Load_In;
  logic                  Ready_Out;
  logic                  Shift_Enable_In;
  logic                  Serial_Data_Out;
  logic                  Serial_Valid_Out;
  logic                  Frame_Start_Out;
  logic                  Frame_Done_Out;
  logic [CntW-1:0]       Bit_Count_Out;

  modport slave (
    input  Parallel_Data_In,
    input  Load_In,
    input  Shift_Enable_In,
    output Ready_Out,
    output Serial_Data_Out,
    output Serial_Valid_Out,
    output Frame_Start_Out,
    output Frame_Done_Out,
    output Bit_Count_Out
  );

  modport master (
    output Parallel_Data_In,
    output Load_In,
    output Shift_Enable_In,
    input  Ready_Out,
    input  Serial_Data_Out,
    input  Serial_Valid_Out,
    input  Frame_Start_Out,
    input  Frame_Done_Out,
    input  Bit_Count_Out
  );
endinterface

// File: rtl/piso_serializer_32_bit.sv
// Parallel-in/serial-out serializer. Captures one word per Load/Ready handshake
// and presents it one bit per enabled cycle, with stall, frame-start and
// frame-done markers. All state changes on the falling edge of Clk_In.
// Ports:
//   Clk_In   : system clock (falling-edge active)
//   Reset_In : asynchronous reset, active-high
//   bus      : piso_serializer_32_bit_if.slave (data, handshake, frame outputs)
// Parameters:
//   DATA_WIDTH : word width (>= 2)
//   MSB_FIRST  : 1 = bit DATA_WIDTH-1 first, 0 = bit 0 first
module piso_serializer_32_bit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic                      Clk_In,
  input  logic                      Reset_In,
  piso_serializer_32_bit_if.slave   bus
);
  localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(DATA_WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_t;

  state_t                r_state, w_state_next;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_next;
  logic [CntW-1:0]       r_count, w_count_next;
  logic                  r_done,  w_done_next;
  logic                  w_last;
  logic                  w_ready;
  logic                  w_accept;

  // Last bit is consumed on this edge; this is what opens the back-to-back window.
  assign w_last   = (r_state == StShift) && (r_count == LastIdx) && bus.Shift_Enable_In;
  assign w_ready  = (r_state == StIdle) || w_last;
  assign w_accept = bus.Load_In && w_ready;

  // State register
  always_ff @(negedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath registers
  always_ff @(negedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      r_shift <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_shift <= w_shift_next;
      r_count <= w_count_next;
      r_done  <= w_done_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (bus.Load_In) w_state_next = StShift;
      StShift: if (w_last && !bus.Load_In) w_state_next = StIdle;
    endcase
  end

  // Datapath next-state
  always_comb begin
    w_shift_next = r_shift;
    w_count_next = r_count;
    w_done_next  = w_last;
    if (w_accept) begin
      w_shift_next = bus.Parallel_Data_In;
      w_count_next = '0;
    end else if (w_last) begin
      // Frame ends with no follow-on word; park the counter at 0 for IDLE.
      w_count_next = '0;
    end else if ((r_state == StShift) && bus.Shift_Enable_In) begin
      w_shift_next = MSB_FIRST ? {r_shift[DATA_WIDTH-2:0], 1'b0}
                               : {1'b0, r_shift[DATA_WIDTH-1:1]};
      w_count_next = r_count + CntW'(1);
    end
  end

  // Outputs: serial bit and markers come from registers only.
  always_comb begin
    bus.Serial_Valid_Out = (r_state == StShift);
    bus.Serial_Data_Out  = (r_state == StShift) &&
                           (MSB_FIRST ? r_shift[DATA_WIDTH-1] : r_shift[0]);
    bus.Frame_Start_Out  = (r_state == StShift) && (r_count == '0);
    bus.Frame_Done_Out   = r_done;
    bus.Bit_Count_Out    = r_count;
    bus.Ready_Out        = w_ready;
  end
endmodule

// File: tb/tb_piso_serializer_32_bit.sv
module tb_piso_serializer_32_bit;
  logic clk;
  logic rst;
  logic        ld  [2];
  logic        se  [2];
  logic [31:0] dat [2];

  logic       o_sdo [2];
  logic       o_val [2];
  logic       o_fs  [2];
  logic       o_fd  [2];
  logic       o_rdy [2];
  logic [4:0] o_cnt [2];

  int n_checks = 0;
  int n_err    = 0;

  // Index 0: MSB-first instance, index 1: LSB-first instance.
  piso_serializer_32_bit_if #(.DATA_WIDTH(32)) if_m ();
  piso_serializer_32_bit_if #(.DATA_WIDTH(32)) if_l ();

  piso_serializer_32_bit #(.DATA_WIDTH(32), .MSB_FIRST(1'b1)) dut_m (
    .Clk_In(clk), .Reset_In(rst), .bus(if_m)
  );
  piso_serializer_32_bit #(.DATA_WIDTH(32), .MSB_FIRST(1'b0)) dut_l (
    .Clk_In(clk), .Reset_In(rst), .bus(if_l)
  );

  assign if_m.Load_In          = ld[0];
  assign if_m.Shift_Enable_In  = se[0];
  assign if_m.Parallel_Data_In = dat[0];
  assign if_l.Load_In          = ld[1];
  assign if_l.Shift_Enable_In  = se[1];
  assign if_l.Parallel_Data_In = dat[1];

  assign o_sdo[0] = if_m.Serial_Data_Out;  assign o_sdo[1] = if_l.Serial_Data_Out;
  assign o_val[0] = if_m.Serial_Valid_Out; assign o_val[1] = if_l.Serial_Valid_Out;
  assign o_fs[0]  = if_m.Frame_Start_Out;  assign o_fs[1]  = if_l.Frame_Start_Out;
  assign o_fd[0]  = if_m.Frame_Done_Out;   assign o_fd[1]  = if_l.Frame_Done_Out;
  assign o_rdy[0] = if_m.Ready_Out;        assign o_rdy[1] = if_l.Ready_Out;
  assign o_cnt[0] = if_m.Bit_Count_Out;    assign o_cnt[1] = if_l.Bit_Count_Out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the captured word plus the index of the bit on show.
  logic [31:0] m_word [2];
  int          m_idx  [2];
  bit          m_busy [2];
  bit          m_done [2];

  function automatic bit m_bit(input int d);
    if (!m_busy[d]) return 1'b0;
    return (d == 0) ? m_word[d][31 - m_idx[d]] : m_word[d][m_idx[d]];
  endfunction

  function automatic bit m_ready(input int d);
    return !m_busy[d] || (m_idx[d] == 31 && se[d]);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 1'b0; m_idx[d] = 0; m_done[d] = 1'b0; m_word[d] = '0;
    end
  endtask

  task automatic model_edge(input int d);
    bit rdy;
    rdy = m_ready(d);
    m_done[d] = 1'b0;
    if (m_busy[d] && se[d]) begin
      if (m_idx[d] == 31) begin
        m_done[d] = 1'b1; m_busy[d] = 1'b0; m_idx[d] = 0;
      end else begin
        m_idx[d]++;
      end
    end
    if (ld[d] && rdy) begin
      m_word[d] = dat[d]; m_idx[d] = 0; m_busy[d] = 1'b1;
    end
  endtask

  task automatic chk(input int d, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d @%0t: got %0h expected %0h", name, d, $time, act, exp);
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      chk(d, "serial_data",  32'(o_sdo[d]), 32'(m_bit(d)));
      chk(d, "serial_valid", 32'(o_val[d]), 32'(m_busy[d]));
      chk(d, "frame_start",  32'(o_fs[d]),  32'(m_busy[d] && m_idx[d] == 0));
      chk(d, "frame_done",   32'(o_fd[d]),  32'(m_done[d]));
      chk(d, "bit_count",    32'(o_cnt[d]), 32'(m_idx[d]));
      chk(d, "ready",        32'(o_rdy[d]), 32'(m_ready(d)));
    end
  endtask

  // Called just after a rising edge with inputs already set for the next falling edge.
  task automatic cycle();
    #1;
    check_all();
    @(negedge clk);
    model_edge(0);
    model_edge(1);
    @(posedge clk);
  endtask

  typedef struct {
    int          d;
    logic [31:0] word;
    int          sa, la, sb, lb;   // stall at bit sa for la cycles, at sb for lb
    int          bl;               // bit index at which to pulse a rejected load
    bit          exp_first;
    int          exp_len;          // cycles with Serial_Valid_Out high
  } vec_t;

  task automatic run_vec(input vec_t v);
    int d, nb, nval, budget, ra, rb;
    logic [31:0] got;
    bit first;
    d = v.d; nb = 0; nval = 0; got = '0; first = 1'b0; ra = v.la; rb = v.lb;
    ld[d] = 1'b1; dat[d] = v.word; se[d] = 1'b1;
    cycle();
    ld[d] = 1'b0; dat[d] = $urandom;
    budget = 200;
    while (m_busy[d] && budget > 0) begin
      if (o_val[d]) nval++;
      se[d] = 1'b1;
      if (m_idx[d] == v.sa && ra > 0) begin se[d] = 1'b0; ra--; end
      else if (m_idx[d] == v.sb && rb > 0) begin se[d] = 1'b0; rb--; end
      ld[d] = (m_idx[d] == v.bl);
      if (ld[d]) dat[d] = 32'h1234_5678;
      if (se[d]) begin
        if (nb == 0) first = o_sdo[d];
        if (nb < 32) got[(d == 0) ? 31 - nb : nb] = o_sdo[d];
        nb++;
      end
      cycle();
      budget--;
    end
    ld[d] = 1'b0; se[d] = 1'b1;
    cycle();
    chk(d, "frame_in_budget", 32'(budget > 0), 32'd1);
    chk(d, "frame_bits", got, v.word);
    chk(d, "first_bit", 32'(first), 32'(v.exp_first));
    chk(d, "frame_len", 32'(nval), 32'(v.exp_len));
    chk(d, "bits_consumed", 32'(nb), 32'd32);
  endtask

  task automatic back_to_back();
    int ones_a, ones_b, nval, d1, d2;
    ones_a = 0; ones_b = 0; nval = 0; d1 = -1; d2 = -1;
    ld[0] = 1'b1; dat[0] = 32'hFFFF_FFFF; se[0] = 1'b1;
    cycle();
    dat[0] = 32'h0000_0000;
    for (int c = 1; c <= 65; c++) begin
      if (c <= 64 && o_val[0]) nval++;
      if (o_fd[0]) begin
        if (d1 < 0) d1 = c; else d2 = c;
      end
      if (c <= 32) ones_a += int'(o_sdo[0]);
      else if (c <= 64) ones_b += int'(o_sdo[0]);
      cycle();
      if (c == 32) ld[0] = 1'b0;
    end
    chk(0, "b2b_ones_first", 32'(ones_a), 32'd32);
    chk(0, "b2b_ones_second", 32'(ones_b), 32'd0);
    chk(0, "b2b_valid_cycles", 32'(nval), 32'd64);
    chk(0, "b2b_done1_cycle", 32'(d1), 32'd33);
    chk(0, "b2b_done2_cycle", 32'(d2), 32'd65);
  endtask

  task automatic reset_mid_frame();
    ld[0] = 1'b1; dat[0] = 32'hFFFF_FFFF; se[0] = 1'b1;
    cycle();
    ld[0] = 1'b0;
    repeat (12) cycle();
    chk(0, "pre_reset_count", 32'(o_cnt[0]), 32'd12);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    @(posedge clk);
    #1 check_all();
    #1 rst = 1'b0;
    @(posedge clk);
  endtask

  vec_t tbl [7];

  initial begin
    tbl[0] = '{d: 0, word: 32'hA5A5_0F0F, sa: -1, la: 0, sb: -1, lb: 0, bl: -1,
               exp_first: 1'b1, exp_len: 32};
    tbl[1] = '{d: 1, word: 32'h0000_0001, sa: -1, la: 0, sb: -1, lb: 0, bl: -1,
               exp_first: 1'b1, exp_len: 32};
    tbl[2] = '{d: 0, word: 32'h8000_0000, sa: 0, la: 5, sb: 17, lb: 3, bl: -1,
               exp_first: 1'b1, exp_len: 40};
    tbl[3] = '{d: 0, word: 32'hDEAD_BEEF, sa: -1, la: 0, sb: -1, lb: 0, bl: 10,
               exp_first: 1'b1, exp_len: 32};
    tbl[4] = '{d: 1, word: 32'h0000_FFFF, sa: -1, la: 0, sb: -1, lb: 0, bl: -1,
               exp_first: 1'b1, exp_len: 32};
    tbl[5] = '{d: 0, word: 32'h0000_FFFF, sa: -1, la: 0, sb: -1, lb: 0, bl: -1,
               exp_first: 1'b0, exp_len: 32};
    tbl[6] = '{d: 1, word: 32'hC3C3_1234, sa: 4, la: 2, sb: 31, lb: 4, bl: 20,
               exp_first: 1'b0, exp_len: 38};

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      ld[d] = 1'b0; se[d] = 1'b1; dat[d] = '0;
    end
    #1;
    model_reset();
    check_all();
    #11 rst = 1'b0;
    @(posedge clk);

    for (int i = 0; i < 7; i++) begin
      if (i == 5) begin
        back_to_back();
        reset_mid_frame();
      end
      run_vec(tbl[i]);
    end

    repeat (600) begin
      for (int d = 0; d < 2; d++) begin
        ld[d]  = ($urandom_range(0, 3) == 0);
        se[d]  = ($urandom_range(0, 3) != 0);
        dat[d] = $urandom;
      end
      cycle();
    end
    for (int d = 0; d < 2; d++) begin
      ld[d] = 1'b0; se[d] = 1'b1;
    end
    repeat (40) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
